// File: rtl/bank_request_scheduler.sv
// Per-bank request scheduler for a banked triple-ported memory.
// Captures requests from three ports that target this bank, issues them in
// order to a 1RW1R SRAM (at most one on RW plus one read on R per cycle),
// holds off upstream with freeze_inputs while a backlog remains, and routes
// SRAM results back to the originating port together with the request tag.
module bank_request_scheduler #(
    parameter int BANK_ID = 0,
    parameter int ROW_W   = 10,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [TAG_W-1:0]  port1_req_tag_in,
    input  logic [11:0]       port1_addr,
    input  logic [DATA_W-1:0] port1_data_in,
    input  logic              port1_wen,
    input  logic              port1_valid,
    input  logic [TAG_W-1:0]  port2_req_tag_in,
    input  logic [11:0]       port2_addr,
    input  logic [DATA_W-1:0] port2_data_in,
    input  logic              port2_wen,
    input  logic              port2_valid,
    input  logic [TAG_W-1:0]  port3_req_tag_in,
    input  logic [11:0]       port3_addr,
    input  logic [DATA_W-1:0] port3_data_in,
    input  logic              port3_wen,
    input  logic              port3_valid,
    input  logic [DATA_W-1:0] sram_rw_dout,
    input  logic [DATA_W-1:0] sram_r_dout,
    output logic [ROW_W-1:0]  rws_addr,
    output logic [DATA_W-1:0] rws_data_in,
    output logic              rws_w_en,
    output logic              rws_valid,
    output logic [ROW_W-1:0]  rs_addr,
    output logic              rs_valid,
    output logic [TAG_W-1:0]  port1_req_tag_out,
    output logic [DATA_W-1:0] port1_data_out,
    output logic              port1_valid_out,
    output logic [TAG_W-1:0]  port2_req_tag_out,
    output logic [DATA_W-1:0] port2_data_out,
    output logic              port2_valid_out,
    output logic [TAG_W-1:0]  port3_req_tag_out,
    output logic [DATA_W-1:0] port3_data_out,
    output logic              port3_valid_out,
    output logic              freeze_inputs
);

    localparam logic [1:0] BANK_SEL = BANK_ID[1:0];

    // Queue entry: originating port (1..3), tag, row, write data, write flag.
    typedef struct packed {
        logic [1:0]        port;
        logic [TAG_W-1:0]  tag;
        logic [ROW_W-1:0]  row;
        logic [DATA_W-1:0] data;
        logic              wen;
    } entry_t;

    // Response metadata for one SRAM port, tracking the access now in flight.
    typedef struct packed {
        logic              vld;
        logic [1:0]        port;
        logic [TAG_W-1:0]  tag;
        logic              is_wr;
    } meta_t;

    entry_t            r_q [3];
    logic [1:0]        r_cnt;
    meta_t             r_rw_meta;
    meta_t             r_r_meta;

    entry_t            w_in [3];
    entry_t            w_q_nxt [3];
    logic [1:0]        w_cnt_nxt;
    logic [2:0]        w_hit;
    logic              w_e0_present;
    logic              w_e1_issue;
    logic [1:0]        w_issue_cnt;
    logic [1:0]        w_remain;
    logic              w_freeze;
    meta_t             w_rw_meta_nxt;
    meta_t             w_r_meta_nxt;
    logic [2:0]        w_vo;
    logic [TAG_W-1:0]  w_tag_o [3];
    logic [DATA_W-1:0] w_dat_o [3];

    assign w_in[0] = {2'd1, port1_req_tag_in, port1_addr[ROW_W-1:0], port1_data_in, port1_wen};
    assign w_in[1] = {2'd2, port2_req_tag_in, port2_addr[ROW_W-1:0], port2_data_in, port2_wen};
    assign w_in[2] = {2'd3, port3_req_tag_in, port3_addr[ROW_W-1:0], port3_data_in, port3_wen};

    // The head always issues; the second entry rides the R port only when it
    // is a read that does not collide with a same-row write at the head, so a
    // read-after-write waits one cycle and observes the new data.
    always_comb begin
        w_e0_present = (r_cnt != 2'd0);
        if ((r_cnt >= 2'd2) && !r_q[1].wen && !(r_q[0].wen && (r_q[0].row == r_q[1].row))) begin
            w_e1_issue = 1'b1;
        end else begin
            w_e1_issue = 1'b0;
        end
        w_issue_cnt = {1'b0, w_e0_present} + {1'b0, w_e1_issue};
        w_remain    = r_cnt - w_issue_cnt;
        w_freeze    = (w_remain != 2'd0);
    end

    // New requests are accepted only when this cycle drains the queue.
    always_comb begin
        w_hit[0] = port1_valid && (port1_addr[11:10] == BANK_SEL) && !w_freeze;
        w_hit[1] = port2_valid && (port2_addr[11:10] == BANK_SEL) && !w_freeze;
        w_hit[2] = port3_valid && (port3_addr[11:10] == BANK_SEL) && !w_freeze;
    end

    // Next queue contents: shift out issued entries, or load hits compacted in port order.
    always_comb begin
        w_q_nxt   = r_q;
        w_cnt_nxt = r_cnt;
        if (w_freeze) begin
            case (w_issue_cnt)
                2'd1: begin
                    w_q_nxt[0] = r_q[1];
                    w_q_nxt[1] = r_q[2];
                end
                2'd2: begin
                    w_q_nxt[0] = r_q[2];
                end
                default: begin
                    w_q_nxt = r_q;
                end
            endcase
            w_cnt_nxt = w_remain;
        end else begin
            w_q_nxt[0] = w_hit[0] ? w_in[0] : (w_hit[1] ? w_in[1] : w_in[2]);
            w_q_nxt[1] = (w_hit[0] && w_hit[1]) ? w_in[1] : w_in[2];
            w_q_nxt[2] = w_in[2];
            w_cnt_nxt  = {1'b0, w_hit[0]} + {1'b0, w_hit[1]} + {1'b0, w_hit[2]};
        end
    end

    // SRAM command outputs, forced to zero when the corresponding port is idle.
    always_comb begin
        if (w_e0_present) begin
            rws_valid   = 1'b1;
            rws_w_en    = r_q[0].wen;
            rws_addr    = r_q[0].row;
            rws_data_in = r_q[0].data;
        end else begin
            rws_valid   = 1'b0;
            rws_w_en    = 1'b0;
            rws_addr    = '0;
            rws_data_in = '0;
        end
        if (w_e1_issue) begin
            rs_valid = 1'b1;
            rs_addr  = r_q[1].row;
        end else begin
            rs_valid = 1'b0;
            rs_addr  = '0;
        end
        freeze_inputs = w_freeze;
    end

    // Metadata that travels alongside each SRAM access to steer its result.
    always_comb begin
        if (w_e0_present) begin
            w_rw_meta_nxt = {1'b1, r_q[0].port, r_q[0].tag, r_q[0].wen};
        end else begin
            w_rw_meta_nxt = '0;
        end
        if (w_e1_issue) begin
            w_r_meta_nxt = {1'b1, r_q[1].port, r_q[1].tag, 1'b0};
        end else begin
            w_r_meta_nxt = '0;
        end
    end

    // Queue and in-flight metadata state; reset drops everything pending.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 3; i++) begin
                r_q[i] <= '0;
            end
            r_cnt     <= 2'd0;
            r_rw_meta <= '0;
            r_r_meta  <= '0;
        end else begin
            r_q       <= w_q_nxt;
            r_cnt     <= w_cnt_nxt;
            r_rw_meta <= w_rw_meta_nxt;
            r_r_meta  <= w_r_meta_nxt;
        end
    end

    // Route SRAM results to the port named by each metadata register; a port
    // never has two accesses in flight, so at most one source matches.
    always_comb begin
        for (int p = 0; p < 3; p++) begin
            if (r_rw_meta.vld && (r_rw_meta.port == 2'(p + 1))) begin
                w_vo[p]    = 1'b1;
                w_tag_o[p] = r_rw_meta.tag;
                w_dat_o[p] = r_rw_meta.is_wr ? '0 : sram_rw_dout;
            end else if (r_r_meta.vld && (r_r_meta.port == 2'(p + 1))) begin
                w_vo[p]    = 1'b1;
                w_tag_o[p] = r_r_meta.tag;
                w_dat_o[p] = sram_r_dout;
            end else begin
                w_vo[p]    = 1'b0;
                w_tag_o[p] = '0;
                w_dat_o[p] = '0;
            end
        end
    end

    assign port1_valid_out   = w_vo[0];
    assign port1_req_tag_out = w_tag_o[0];
    assign port1_data_out    = w_dat_o[0];
    assign port2_valid_out   = w_vo[1];
    assign port2_req_tag_out = w_tag_o[1];
    assign port2_data_out    = w_dat_o[1];
    assign port3_valid_out   = w_vo[2];
    assign port3_req_tag_out = w_tag_o[2];
    assign port3_data_out    = w_dat_o[2];

endmodule

// File: tb/tb_bank_request_scheduler.sv
// Self-checking bench for bank_request_scheduler (BANK_ID=0) with a
// behavioural 1RW1R SRAM and a per-port response scoreboard.
module tb_bank_request_scheduler;

    typedef struct packed {
        logic [1:0]  tag;
        logic [15:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic [1:0]  tag_in [1:3];
    logic [11:0] addr   [1:3];
    logic [15:0] din    [1:3];
    logic        wen    [1:3];
    logic        vld    [1:3];
    logic [1:0]  tag_out [1:3];
    logic [15:0] dout    [1:3];
    logic        vout    [1:3];
    logic [15:0] sram_rw_dout;
    logic [15:0] sram_r_dout;
    logic [9:0]  rws_addr;
    logic [15:0] rws_data_in;
    logic        rws_w_en;
    logic        rws_valid;
    logic [9:0]  rs_addr;
    logic        rs_valid;
    logic        freeze_inputs;

    logic [15:0] mem    [0:1023];
    logic [15:0] shadow [0:1023];
    logic        mem_ready = 1'b0;
    exp_t        sb1 [$];
    exp_t        sb2 [$];
    exp_t        sb3 [$];
    int          total = 0;
    int          bad   = 0;

    bank_request_scheduler #(.BANK_ID(0), .ROW_W(10), .DATA_W(16), .TAG_W(2)) dut (
        .clk(clk), .reset_n(reset_n),
        .port1_req_tag_in(tag_in[1]), .port1_addr(addr[1]), .port1_data_in(din[1]),
        .port1_wen(wen[1]), .port1_valid(vld[1]),
        .port2_req_tag_in(tag_in[2]), .port2_addr(addr[2]), .port2_data_in(din[2]),
        .port2_wen(wen[2]), .port2_valid(vld[2]),
        .port3_req_tag_in(tag_in[3]), .port3_addr(addr[3]), .port3_data_in(din[3]),
        .port3_wen(wen[3]), .port3_valid(vld[3]),
        .sram_rw_dout(sram_rw_dout), .sram_r_dout(sram_r_dout),
        .rws_addr(rws_addr), .rws_data_in(rws_data_in), .rws_w_en(rws_w_en), .rws_valid(rws_valid),
        .rs_addr(rs_addr), .rs_valid(rs_valid),
        .port1_req_tag_out(tag_out[1]), .port1_data_out(dout[1]), .port1_valid_out(vout[1]),
        .port2_req_tag_out(tag_out[2]), .port2_data_out(dout[2]), .port2_valid_out(vout[2]),
        .port3_req_tag_out(tag_out[3]), .port3_data_out(dout[3]), .port3_valid_out(vout[3]),
        .freeze_inputs(freeze_inputs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] pattern(input int i);
        logic [15:0] v;
        v = 16'(i);
        return 16'hA000 + v * 16'd7;
    endfunction

    // Behavioural SRAM: registered read data one cycle after issue.
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 1024; i++) mem[i] <= pattern(i);
            mem_ready <= 1'b1;
        end else begin
            if (rws_valid) begin
                if (rws_w_en) mem[rws_addr] <= rws_data_in;
                else          sram_rw_dout  <= mem[rws_addr];
            end
            if (rs_valid) sram_r_dout <= mem[rs_addr];
        end
    end

    function automatic int sb_size(input int p);
        case (p)
            1: return sb1.size();
            2: return sb2.size();
            default: return sb3.size();
        endcase
    endfunction

    task automatic sb_push(input int p, input exp_t e);
        case (p)
            1: sb1.push_back(e);
            2: sb2.push_back(e);
            default: sb3.push_back(e);
        endcase
    endtask

    task automatic sb_pop(input int p, output exp_t e);
        case (p)
            1: e = sb1.pop_front();
            2: e = sb2.pop_front();
            default: e = sb3.pop_front();
        endcase
    endtask

    task automatic clear_inputs();
        for (int p = 1; p <= 3; p++) begin
            tag_in[p] = 2'd0; addr[p] = 12'd0; din[p] = 16'd0; wen[p] = 1'b0; vld[p] = 1'b0;
        end
    endtask

    // Present a request; when it is expected to be accepted, record the
    // response it must produce and apply a write to the shadow memory.
    task automatic drive(input int p, input logic [11:0] a, input logic [15:0] d,
                         input logic w, input logic [1:0] t, input bit accept);
        tag_in[p] = t; addr[p] = a; din[p] = d; wen[p] = w; vld[p] = 1'b1;
        if (accept) begin
            if (w) begin
                shadow[a[9:0]] = d;
                sb_push(p, '{tag: t, data: 16'h0000});
            end else begin
                sb_push(p, '{tag: t, data: shadow[a[9:0]]});
            end
        end
    endtask

    // Advance one clock; at the falling edge every port's response is
    // scored against the expected-response queue.
    task automatic cycle();
        exp_t e;
        @(negedge clk);
        if (reset_n) begin
            for (int p = 1; p <= 3; p++) begin
                total++;
                if (vout[p]) begin
                    if (sb_size(p) == 0) begin
                        bad++;
                        $display("FAIL resp_unexpected port%0d: got tag=%0d data=%h, required no response",
                                 p, tag_out[p], dout[p]);
                    end else begin
                        sb_pop(p, e);
                        if ({tag_out[p], dout[p]} !== e) begin
                            bad++;
                            $display("FAIL resp_port%0d: got tag=%0d data=%h, required tag=%0d data=%h",
                                     p, tag_out[p], dout[p], e.tag, e.data);
                        end
                    end
                end else if ({tag_out[p], dout[p]} !== 18'd0) begin
                    bad++;
                    $display("FAIL resp_idle_port%0d: got tag=%0d data=%h, required 0", p, tag_out[p], dout[p]);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [96:0] all_outs();
        return {rws_addr, rws_data_in, rws_w_en, rws_valid, rs_addr, rs_valid, freeze_inputs,
                tag_out[1], dout[1], vout[1], tag_out[2], dout[2], vout[2],
                tag_out[3], dout[3], vout[3]};
    endfunction

    task automatic test_reset();
        reset_n = 1'b0;
        clear_inputs();
        cycle(); cycle();
        total++;
        if (all_outs() !== 97'd0) begin bad++; $display("FAIL reset_outputs: got %h required 0", all_outs()); end
        reset_n = 1'b1;
        cycle();
        total++;
        if (all_outs() !== 97'd0) begin bad++; $display("FAIL idle_after_reset: got %h required 0", all_outs()); end
    endtask

    task automatic test_single_read();
        drive(1, 12'h005, 16'h0000, 1'b0, 2'd2, 1'b1);
        cycle();
        clear_inputs();
        total++;
        if ({rws_valid, rws_w_en, rws_addr, rs_valid, freeze_inputs} !== {1'b1, 1'b0, 10'h005, 1'b0, 1'b0}) begin
            bad++; $display("FAIL single_issue: got v=%b w=%b a=%h rs=%b fz=%b required v=1 w=0 a=005 rs=0 fz=0",
                            rws_valid, rws_w_en, rws_addr, rs_valid, freeze_inputs);
        end
        cycle();
        total++;
        if ({vout[1], tag_out[1], dout[1], vout[2], vout[3]} !== {1'b1, 2'd2, pattern(5), 1'b0, 1'b0}) begin
            bad++; $display("FAIL single_resp: got v=%b tag=%0d data=%h v2=%b v3=%b required v=1 tag=2 data=%h",
                            vout[1], tag_out[1], dout[1], vout[2], vout[3], pattern(5));
        end
        cycle();
    endtask

    task automatic test_three_reads();
        drive(1, 12'h001, 16'h0, 1'b0, 2'd1, 1'b1);
        drive(2, 12'h002, 16'h0, 1'b0, 2'd2, 1'b1);
        drive(3, 12'h003, 16'h0, 1'b0, 2'd3, 1'b1);
        cycle();
        clear_inputs();
        total++;
        if ({rws_valid, rws_addr, rs_valid, rs_addr, freeze_inputs} !== {1'b1, 10'h001, 1'b1, 10'h002, 1'b1}) begin
            bad++; $display("FAIL reads_issue1: got rw=%b/%h r=%b/%h fz=%b required rw=1/001 r=1/002 fz=1",
                            rws_valid, rws_addr, rs_valid, rs_addr, freeze_inputs);
        end
        cycle();
        total++;
        if ({rws_valid, rws_addr, rs_valid, freeze_inputs, vout[1], vout[2], vout[3]} !==
            {1'b1, 10'h003, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
            bad++; $display("FAIL reads_issue2: got rw=%b/%h r=%b fz=%b vo=%b%b%b required rw=1/003 r=0 fz=0 vo=110",
                            rws_valid, rws_addr, rs_valid, freeze_inputs, vout[1], vout[2], vout[3]);
        end
        cycle();
        total++;
        if ({vout[1], vout[2], vout[3], rws_valid} !== 4'b0010) begin
            bad++; $display("FAIL reads_resp3: got vo=%b%b%b rw=%b required vo=001 rw=0",
                            vout[1], vout[2], vout[3], rws_valid);
        end
        cycle();
    endtask

    task automatic test_three_writes();
        drive(1, 12'h001, 16'h1111, 1'b1, 2'd0, 1'b1);
        drive(2, 12'h002, 16'h2222, 1'b1, 2'd1, 1'b1);
        drive(3, 12'h003, 16'h3333, 1'b1, 2'd2, 1'b1);
        for (int k = 1; k <= 3; k++) begin
            cycle();
            clear_inputs();
            total++;
            if ({rws_valid, rws_w_en, rws_addr, rws_data_in, rs_valid, freeze_inputs} !==
                {1'b1, 1'b1, 10'(k), 16'(k * 16'h1111), 1'b0, (k < 3)}) begin
                bad++; $display("FAIL writes_issue%0d: got v=%b w=%b a=%h d=%h rs=%b fz=%b", k,
                                rws_valid, rws_w_en, rws_addr, rws_data_in, rs_valid, freeze_inputs);
            end
        end
        cycle();
        total++;
        if ({rws_valid, vout[3], dout[3]} !== {1'b0, 1'b1, 16'h0000}) begin
            bad++; $display("FAIL writes_ack3: got rw=%b v3=%b d3=%h required rw=0 v3=1 d3=0000",
                            rws_valid, vout[3], dout[3]);
        end
        drive(2, 12'h002, 16'h0, 1'b0, 2'd3, 1'b1);
        cycle();
        clear_inputs();
        cycle();
        total++;
        if ({vout[2], dout[2]} !== {1'b1, 16'h2222}) begin
            bad++; $display("FAIL readback_row2: got v=%b data=%h required v=1 data=2222", vout[2], dout[2]);
        end
        cycle();
    endtask

    task automatic test_raw();
        drive(1, 12'h010, 16'hBEEF, 1'b1, 2'd1, 1'b1);
        drive(2, 12'h010, 16'h0000, 1'b0, 2'd2, 1'b1);
        cycle();
        clear_inputs();
        total++;
        if ({rws_valid, rws_w_en, rs_valid, freeze_inputs} !== 4'b1101) begin
            bad++; $display("FAIL raw_defer: got rw=%b w=%b rs=%b fz=%b required rw=1 w=1 rs=0 fz=1",
                            rws_valid, rws_w_en, rs_valid, freeze_inputs);
        end
        cycle();
        total++;
        if ({rws_valid, rws_w_en, rws_addr, freeze_inputs, vout[1], vout[2]} !== {1'b1, 1'b0, 10'h010, 1'b0, 1'b1, 1'b0}) begin
            bad++; $display("FAIL raw_issue2: got rw=%b w=%b a=%h fz=%b v1=%b v2=%b",
                            rws_valid, rws_w_en, rws_addr, freeze_inputs, vout[1], vout[2]);
        end
        cycle();
        total++;
        if ({vout[2], dout[2]} !== {1'b1, 16'hBEEF}) begin
            bad++; $display("FAIL raw_data: got v=%b data=%h required v=1 data=beef", vout[2], dout[2]);
        end
        cycle();
    endtask

    task automatic test_ignore();
        drive(1, 12'h805, 16'h0000, 1'b0, 2'd1, 1'b0);
        drive(2, 12'hC07, 16'h5555, 1'b1, 2'd2, 1'b0);
        cycle();
        clear_inputs();
        total++;
        if ({rws_valid, rs_valid, freeze_inputs} !== 3'b000) begin
            bad++; $display("FAIL other_bank: got rw=%b rs=%b fz=%b required 000", rws_valid, rs_valid, freeze_inputs);
        end
        cycle();
        drive(1, 12'h004, 16'h0, 1'b0, 2'd0, 1'b1);
        drive(2, 12'h005, 16'h0, 1'b0, 2'd1, 1'b1);
        drive(3, 12'h006, 16'h0, 1'b0, 2'd2, 1'b1);
        cycle();
        drive(1, 12'h001, 16'hDEAD, 1'b1, 2'd3, 1'b0);
        drive(2, 12'h007, 16'h0, 1'b0, 2'd3, 1'b0);
        drive(3, 12'h008, 16'h0, 1'b0, 2'd3, 1'b0);
        cycle();
        clear_inputs();
        total++;
        if ({rws_valid, rws_addr, rs_valid, freeze_inputs} !== {1'b1, 10'h006, 1'b0, 1'b0}) begin
            bad++; $display("FAIL frozen_queue: got rw=%b a=%h rs=%b fz=%b required rw=1 a=006 rs=0 fz=0",
                            rws_valid, rws_addr, rs_valid, freeze_inputs);
        end
        cycle();
        total++;
        if ({rws_valid, rs_valid} !== 2'b00) begin
            bad++; $display("FAIL frozen_ignored: got rw=%b rs=%b required 00", rws_valid, rs_valid);
        end
        drive(1, 12'h001, 16'h0, 1'b0, 2'd2, 1'b1);
        cycle();
        clear_inputs();
        cycle();
        cycle();
    endtask

    task automatic test_reset_mid();
        drive(1, 12'h008, 16'h0, 1'b0, 2'd1, 1'b1);
        drive(2, 12'h009, 16'h0, 1'b0, 2'd2, 1'b1);
        drive(3, 12'h00A, 16'h0, 1'b0, 2'd3, 1'b1);
        cycle();
        clear_inputs();
        total++;
        if (freeze_inputs !== 1'b1) begin bad++; $display("FAIL mid_freeze: got %b required 1", freeze_inputs); end
        reset_n = 1'b0;
        cycle();
        total++;
        if (all_outs() !== 97'd0) begin bad++; $display("FAIL mid_reset_outputs: got %h required 0", all_outs()); end
        sb1.delete(); sb2.delete(); sb3.delete();
        reset_n = 1'b1;
        cycle();
        total++;
        if (all_outs() !== 97'd0) begin bad++; $display("FAIL post_reset_idle: got %h required 0", all_outs()); end
        drive(3, 12'h3FF, 16'h0, 1'b0, 2'd1, 1'b1);
        cycle();
        clear_inputs();
        total++;
        if ({rws_valid, rws_addr} !== {1'b1, 10'h3FF}) begin
            bad++; $display("FAIL fresh_issue: got rw=%b a=%h required rw=1 a=3ff", rws_valid, rws_addr);
        end
        cycle();
        total++;
        if ({vout[3], tag_out[3], dout[3]} !== {1'b1, 2'd1, pattern(1023)}) begin
            bad++; $display("FAIL fresh_resp: got v=%b tag=%0d data=%h required v=1 tag=1 data=%h",
                            vout[3], tag_out[3], dout[3], pattern(1023));
        end
        cycle();
    endtask

    task automatic test_back_to_back();
        logic [11:0] a;
        logic        acc;
        for (int it = 0; it < 60; it++) begin
            clear_inputs();
            acc = !freeze_inputs;
            for (int p = 1; p <= 3; p++) begin
                if (sb_size(p) == 0 && $urandom_range(0, 3) != 0) begin
                    a = {($urandom_range(0, 3) == 0) ? 2'd2 : 2'd0, 7'd0, 3'($urandom_range(0, 3))};
                    drive(p, a, 16'($urandom), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                          acc && (a[11:10] == 2'd0));
                end
            end
            cycle();
        end
        clear_inputs();
    endtask

    task automatic test_drain();
        for (int k = 0; k < 6; k++) cycle();
        for (int p = 1; p <= 3; p++) begin
            total++;
            if (sb_size(p) != 0) begin
                bad++; $display("FAIL drain_port%0d: got %0d outstanding required 0", p, sb_size(p));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) shadow[i] = pattern(i);
        clear_inputs();
        reset_n = 1'b0;
        test_reset();
        test_single_read();
        test_three_reads();
        test_three_writes();
        test_raw();
        test_ignore();
        test_reset_mid();
        test_back_to_back();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
